// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the datapath (master) and the hazard controller (slave):
// hazard inputs from the stages, enables/flushes and status back to the datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int REGW    = 5,
  parameter int CNTW    = 32
);
  logic                ihit;
  logic                dhit;
  logic                mem_req;
  logic                redirect;
  logic [REGW-1:0]     id_rs;
  logic [REGW-1:0]     id_rt;
  logic                id_uses_rs;
  logic                id_uses_rt;
  logic                ex_memread;
  logic [REGW-1:0]     ex_wsel;
  logic                mc_start;
  logic                halt_in;
  logic [NSTAGES-1:0]  en;
  logic [NSTAGES-1:0]  flush;
  logic [NSTAGES-1:0]  valid;
  logic                halt;
  logic                mc_busy;
  logic [CNTW-1:0]     stall_cycles;

  modport master (
    output ihit, dhit, mem_req, redirect, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_memread, ex_wsel, mc_start, halt_in,
    input  en, flush, valid, halt, mc_busy, stall_cycles
  );

  modport slave (
    input  ihit, dhit, mem_req, redirect, id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_memread, ex_wsel, mc_start, halt_in,
    output en, flush, valid, halt, mc_busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline controller: owns every pipeline-register enable/flush, tracks valid bits,
// sticky halt, multicycle EX occupancy and a saturating fetch-stall counter.
module pipeline_hazard_ctrl #(
  parameter int NSTAGES     = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int MUL_LAT     = 4,
  parameter int REGW        = 5,
  parameter int CNTW        = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  pipeline_hazard_ctrl_if.slave  hz
);
  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MCW-1:0] MC_LOAD = MCW'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    R_NONE, R_HALT, R_DMISS, R_MC, R_LOADUSE, R_FETCH_BR, R_FETCH, R_REDIRECT
  } rule_e;

  logic [NSTAGES-1:0] r_valid;
  logic               r_halt;
  logic [MCW-1:0]     r_mc;
  logic [CNTW-1:0]    r_stall;

  logic [NSTAGES-1:0] w_en;
  logic [NSTAGES-1:0] w_flush;
  logic [REGW-1:0]    w_rs;
  logic [REGW-1:0]    w_rt;
  logic [REGW-1:0]    w_wsel;
  logic               w_load_use;
  logic               w_redirect;
  rule_e              w_rule;

  assign w_rs   = hz.id_rs;
  assign w_rt   = hz.id_rt;
  assign w_wsel = hz.ex_wsel;

  // Register 0 never sees a hazard on $0, and a flushed load (valid=0) never stalls decode.
  assign w_load_use = r_valid[2] && hz.ex_memread && (w_wsel != '0) &&
                      ((hz.id_uses_rs && (w_rs == w_wsel)) ||
                       (hz.id_uses_rt && (w_rt == w_wsel)));
  assign w_redirect = hz.redirect && r_valid[2];

  always_comb begin
    w_rule = R_NONE;
    if (r_halt)                                                  w_rule = R_HALT;
    else if (hz.mem_req && r_valid[NSTAGES-2] && !hz.dhit)       w_rule = R_DMISS;
    else if (r_mc != '0)                                         w_rule = R_MC;
    else if (w_load_use)                                         w_rule = R_LOADUSE;
    else if (!hz.ihit && w_redirect)                             w_rule = R_FETCH_BR;
    else if (!hz.ihit)                                           w_rule = R_FETCH;
    else if (w_redirect)                                         w_rule = R_REDIRECT;
  end

  always_comb begin
    w_en    = '1;
    w_flush = '0;
    case (w_rule)
      R_HALT, R_DMISS: w_en = '0;
      R_MC: begin
        w_en[NSTAGES-3:0]    = '0;
        w_flush[NSTAGES-2]   = 1'b1;
      end
      R_LOADUSE: begin
        w_en[1:0]  = '0;
        w_flush[2] = 1'b1;
      end
      R_FETCH_BR: begin
        w_en[2:0]  = '0;
        w_flush[3] = 1'b1;
      end
      R_FETCH: begin
        w_en[0]    = 1'b0;
        w_flush[1] = 1'b1;
      end
      R_REDIRECT: begin
        for (int i = 1; i <= FLUSH_DEPTH; i++) w_flush[i] = 1'b1;
      end
      default: ;
    endcase
    if (!nRST) begin
      w_en    = '0;
      w_flush = '1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= NSTAGES'(1);
    end else begin
      r_valid[0] <= 1'b1;
      for (int i = 1; i < NSTAGES; i++) begin
        if (w_en[i]) r_valid[i] <= w_flush[i] ? 1'b0 : r_valid[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_halt <= 1'b0;
    else if (hz.halt_in && r_valid[NSTAGES-1]) r_halt <= 1'b1;
  end

  // The multicycle countdown pauses only while a dcache miss freezes the pipe.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mc <= '0;
    end else if (r_mc == '0) begin
      if (hz.mc_start && r_valid[2] && w_en[NSTAGES-2]) r_mc <= MC_LOAD;
    end else if (w_rule != R_DMISS) begin
      r_mc <= r_mc - MCW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_stall <= '0;
    else if (!w_en[0] && !r_halt && (r_stall != '1)) r_stall <= r_stall + CNTW'(1);
  end

  assign hz.en           = w_en;
  assign hz.flush        = w_flush;
  assign hz.valid        = r_valid;
  assign hz.halt         = r_halt;
  assign hz.mc_busy      = (r_mc != '0);
  assign hz.stall_cycles = r_stall;
endmodule
